// File: rtl/mem_access_ctrl.sv
// MEM-stage SRAM access engine: multi-cycle load/store strobe sequence, pipeline
// stall generation and MEM/WB write-back source selection.
module mem_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ADDR_W      = 18
) (
  input  logic              clk_50MHz,
  input  logic              rst,
  input  logic              em_RAM_en,
  input  logic              em_RAM_op,
  input  logic [1:0]        em_DATA_op,
  input  logic              em_REG_op,
  input  logic [15:0]       em_IH,
  input  logic [15:0]       em_PC,
  input  logic [15:0]       em_ALU_data,
  input  logic [15:0]       em_RAM_WB_data,
  input  logic [3:0]        em_WB_addr,
  output logic [ADDR_W-1:0] ram_addr,
  inout  logic [15:0]       ram_data,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic              mem_stall,
  output logic [15:0]       n_mw_WB_data,
  output logic [3:0]        n_mw_WB_addr,
  output logic              n_mw_REG_op
);

  localparam int unsigned LP_WAIT     = (WAIT_CYCLES == 0) ? 1 : WAIT_CYCLES;
  localparam logic [3:0]  LP_CNT_INIT = 4'(LP_WAIT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [15:0]       r_rd_data;
  logic [15:0]       r_wdata;
  logic [ADDR_W-1:0] r_addr;
  logic              r_drive;
  logic              r_ce_n;
  logic              r_oe_n;
  logic              r_we_n;
  logic              w_stall;
  logic              w_store;

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rd_data <= '0;
      r_wdata   <= '0;
      r_addr    <= '0;
      r_drive   <= 1'b0;
      r_ce_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_we_n    <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (em_RAM_en) begin
            r_state <= SETUP;
            r_ce_n  <= 1'b0;
            r_addr  <= ADDR_W'(em_ALU_data);
            r_wdata <= em_RAM_WB_data;
            r_drive <= em_RAM_op;
          end
        end
        SETUP: begin
          r_state <= STROBE;
          r_cnt   <= LP_CNT_INIT;
          r_oe_n  <= em_RAM_op;
          r_we_n  <= ~em_RAM_op;
        end
        STROBE: begin
          if (r_cnt == 4'd0) begin
            r_state <= DONE;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_drive <= 1'b0;
            // OE still low here, so the SRAM is driving the bus on this edge
            if (!r_oe_n) r_rd_data <= ram_data;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Gated by rst so the stall drops the instant reset is asserted
  assign w_stall = rst & (((r_state == IDLE) & em_RAM_en) |
                          (r_state == SETUP) | (r_state == STROBE));
  assign w_store = em_RAM_en & em_RAM_op;

  always_comb begin
    n_mw_WB_data = em_ALU_data;
    case (em_DATA_op)
      2'd0:    n_mw_WB_data = em_ALU_data;
      2'd1:    n_mw_WB_data = r_rd_data;
      2'd2:    n_mw_WB_data = em_PC;
      default: n_mw_WB_data = em_IH;
    endcase
  end

  assign ram_data     = r_drive ? r_wdata : 'z;
  assign ram_addr     = r_addr;
  assign ram_ce_n     = r_ce_n;
  assign ram_oe_n     = r_oe_n;
  assign ram_we_n     = r_we_n;
  assign mem_stall    = w_stall;
  assign n_mw_WB_addr = em_WB_addr;
  assign n_mw_REG_op  = em_REG_op & ~w_stall & ~w_store;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (WAIT_CYCLES 1 and 3), each with an
// SRAM model, checked every cycle against a transaction-phase reference model.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  logic [1:0]       en, op, rop;
  logic [1:0][1:0]  dop;
  logic [1:0][15:0] ih, pc, alu, wd;
  logic [1:0][3:0]  wba;

  wire  [1:0][17:0] addr;
  wire  [1:0]       ce_n, oe_n, we_n, stall, rop_o;
  wire  [1:0][15:0] wbd;
  wire  [1:0][3:0]  wba_o;
  wire  [15:0]      bus0, bus1;

  mem_access_ctrl #(.WAIT_CYCLES(1), .ADDR_W(18)) u_w1 (
    .clk_50MHz(clk), .rst(rst), .em_RAM_en(en[0]), .em_RAM_op(op[0]),
    .em_DATA_op(dop[0]), .em_REG_op(rop[0]), .em_IH(ih[0]), .em_PC(pc[0]),
    .em_ALU_data(alu[0]), .em_RAM_WB_data(wd[0]), .em_WB_addr(wba[0]),
    .ram_addr(addr[0]), .ram_data(bus0), .ram_ce_n(ce_n[0]), .ram_oe_n(oe_n[0]),
    .ram_we_n(we_n[0]), .mem_stall(stall[0]), .n_mw_WB_data(wbd[0]),
    .n_mw_WB_addr(wba_o[0]), .n_mw_REG_op(rop_o[0]));

  mem_access_ctrl #(.WAIT_CYCLES(3), .ADDR_W(18)) u_w3 (
    .clk_50MHz(clk), .rst(rst), .em_RAM_en(en[1]), .em_RAM_op(op[1]),
    .em_DATA_op(dop[1]), .em_REG_op(rop[1]), .em_IH(ih[1]), .em_PC(pc[1]),
    .em_ALU_data(alu[1]), .em_RAM_WB_data(wd[1]), .em_WB_addr(wba[1]),
    .ram_addr(addr[1]), .ram_data(bus1), .ram_ce_n(ce_n[1]), .ram_oe_n(oe_n[1]),
    .ram_we_n(we_n[1]), .mem_stall(stall[1]), .n_mw_WB_data(wbd[1]),
    .n_mw_WB_addr(wba_o[1]), .n_mw_REG_op(rop_o[1]));

  // Unwritten SRAM locations read back as a fixed function of the address
  function automatic logic [15:0] fill(input logic [7:0] a);
    return {a, a} ^ 16'hB5B5;
  endfunction

  logic [15:0] s0 [256];
  logic [15:0] s1 [256];
  bit   [255:0] s0v, s1v;

  always @(posedge clk) begin
    if (!ce_n[0] && !we_n[0]) begin
      s0[addr[0][7:0]]  <= bus0;
      s0v[addr[0][7:0]] <= 1'b1;
    end
  end
  always @(posedge clk) begin
    if (!ce_n[1] && !we_n[1]) begin
      s1[addr[1][7:0]]  <= bus1;
      s1v[addr[1][7:0]] <= 1'b1;
    end
  end

  assign bus0 = (!ce_n[0] && !oe_n[0]) ?
                (s0v[addr[0][7:0]] ? s0[addr[0][7:0]] : fill(addr[0][7:0])) : 16'hzzzz;
  assign bus1 = (!ce_n[1] && !oe_n[1]) ?
                (s1v[addr[1][7:0]] ? s1[addr[1][7:0]] : fill(addr[1][7:0])) : 16'hzzzz;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: ph = cycles since access detection, -1 when none
  int          ph  [2];
  int          stc [2];
  int          sbc [2];
  logic [17:0] sa  [2];
  logic [15:0] rdm [2];
  logic [15:0] mm  [2][256];
  bit   [1:0][255:0] mv;

  bit   [1:0]  pin_on;
  int          pin_st  [2];
  int          pin_sb  [2];
  logic [15:0] pin_wbd [2];
  logic [3:0]  pin_wba [2];
  logic        pin_rop [2];
  bit          pin_ca  [2];
  logic [17:0] pin_addr[2];

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d: got %h want %h at %0t", nm, i, act, exp, $time);
    end
  endtask

  task automatic ev(input int i);
    int          w, cur;
    bit          inb, str, done;
    logic [7:0]  a;
    logic [15:0] b, mrd, e_wbd;
    logic        e_stall;
    w    = (i == 0) ? 1 : 3;
    cur  = (ph[i] < 0 && en[i]) ? 0 : ph[i];
    inb  = (cur >= 1) && (cur <= w + 1);
    str  = (cur >= 2) && (cur <= w + 1);
    done = (cur == w + 2);
    a    = alu[i][7:0];
    b    = (i == 0) ? bus0 : bus1;
    mrd  = mv[i][a] ? mm[i][a] : fill(a);
    if (done && !op[i]) rdm[i] = mrd;
    e_stall = (cur >= 0) && (cur <= w + 1);
    chk("stall", i, stall[i], e_stall);
    chk("ce_n", i, ce_n[i], !inb);
    chk("oe_n", i, oe_n[i], !(str && !op[i]));
    chk("we_n", i, we_n[i], !(str && op[i]));
    if (inb) chk("ram_addr", i, addr[i], {2'b00, alu[i]});
    if (inb && op[i]) chk("wr_bus", i, b, wd[i]);
    if (str && !op[i]) chk("rd_bus", i, b, mrd);
    case (dop[i])
      2'd0:    e_wbd = alu[i];
      2'd1:    e_wbd = rdm[i];
      2'd2:    e_wbd = pc[i];
      default: e_wbd = ih[i];
    endcase
    chk("wb_data", i, wbd[i], e_wbd);
    chk("wb_addr", i, wba_o[i], wba[i]);
    chk("reg_op", i, rop_o[i], rop[i] && !e_stall && !(en[i] && op[i]));
    if (stall[i] && cur != 0) stc[i]++;
    if (!oe_n[i] || !we_n[i]) sbc[i]++;
    if (cur == 1) sa[i] = addr[i];
    if (done && op[i]) begin
      mm[i][a] = wd[i];
      mv[i][a] = 1'b1;
    end
    if (cur < 0 || done) begin
      if (pin_on[i]) begin
        chk("pin_stall_cycles", i, stc[i], pin_st[i]);
        chk("pin_strobe_cycles", i, sbc[i], pin_sb[i]);
        if (pin_ca[i]) chk("pin_addr", i, sa[i], pin_addr[i]);
        chk("pin_wb_data", i, wbd[i], pin_wbd[i]);
        chk("pin_wb_addr", i, wba_o[i], pin_wba[i]);
        chk("pin_reg_op", i, rop_o[i], pin_rop[i]);
      end
      stc[i] = 0;
      sbc[i] = 0;
      ph[i]  = -1;
    end else begin
      ph[i] = cur + 1;
    end
  endtask

  always begin
    @(negedge clk or negedge rst);
    if (!rst) begin
      #1;
      for (int i = 0; i < 2; i++) begin
        chk("rst_ce_n", i, ce_n[i], 1'b1);
        chk("rst_oe_n", i, oe_n[i], 1'b1);
        chk("rst_we_n", i, we_n[i], 1'b1);
        chk("rst_stall", i, stall[i], 1'b0);
        chk("rst_addr", i, addr[i], 18'h0);
        ph[i]  = -1;
        rdm[i] = '0;
        stc[i] = 0;
        sbc[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) ev(i);
    end
  end

  task automatic pin(input int i, input int st, input int sb, input logic [15:0] d,
                     input logic [3:0] wa, input logic r, input bit ca, input logic [17:0] ad);
    pin_st[i] = st; pin_sb[i] = sb; pin_wbd[i] = d; pin_wba[i] = wa;
    pin_rop[i] = r; pin_ca[i] = ca; pin_addr[i] = ad; pin_on[i] = 1'b1;
  endtask

  // Present one instruction and hold it until the stage lets it advance
  task automatic issue(input int i, input logic e, input logic o, input logic [1:0] d,
                       input logic r, input logic [15:0] a, input logic [15:0] w,
                       input logic [15:0] p, input logic [15:0] h, input logic [3:0] wa);
    int   n;
    logic s;
    en[i] = e; op[i] = o; dop[i] = d; rop[i] = r; alu[i] = a;
    wd[i] = w; pc[i] = p; ih[i] = h; wba[i] = wa;
    n = 0;
    do begin
      @(negedge clk);
      s = stall[i];
      @(posedge clk);
      #1;
      n++;
      if (n > 40) begin
        $display("FAIL stall_timeout inst%0d: got stall stuck want release within 40 cycles", i);
        $fatal(1);
      end
    end while (s);
    en[i]     = 1'b0;
    pin_on[i] = 1'b0;
  endtask

  initial begin
    en = '0; op = '0; rop = '0; dop = '0; ih = '0; pc = '0; alu = '0; wd = '0; wba = '0;
    pin_on = '0;
    for (int i = 0; i < 2; i++) begin
      ph[i] = -1; stc[i] = 0; sbc[i] = 0; rdm[i] = '0; sa[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    pin(0, 2, 1, 16'h1234, 4'd2, 1'b0, 1'b1, 18'h01234);
    issue(0, 1'b1, 1'b1, 2'd0, 1'b1, 16'h1234, 16'hBEEF, 16'h0, 16'h0, 4'd2);

    pin(1, 4, 3, 16'hA5A5, 4'd5, 1'b1, 1'b1, 18'h00010);
    issue(1, 1'b1, 1'b0, 2'd1, 1'b1, 16'h0010, 16'h0000, 16'h0, 16'h0, 4'd5);

    pin(1, 0, 0, 16'h0001, 4'd3, 1'b1, 1'b0, 18'h0);
    issue(1, 1'b0, 1'b0, 2'd0, 1'b1, 16'h0001, 16'h0, 16'h0002, 16'h0003, 4'd3);
    pin(1, 0, 0, 16'hA5A5, 4'd3, 1'b1, 1'b0, 18'h0);
    issue(1, 1'b0, 1'b0, 2'd1, 1'b1, 16'h0001, 16'h0, 16'h0002, 16'h0003, 4'd3);
    pin(1, 0, 0, 16'h0002, 4'd3, 1'b1, 1'b0, 18'h0);
    issue(1, 1'b0, 1'b0, 2'd2, 1'b1, 16'h0001, 16'h0, 16'h0002, 16'h0003, 4'd3);
    pin(1, 0, 0, 16'h0003, 4'd3, 1'b1, 1'b0, 18'h0);
    issue(1, 1'b0, 1'b0, 2'd3, 1'b1, 16'h0001, 16'h0, 16'h0002, 16'h0003, 4'd3);

    pin(0, 2, 1, 16'h0020, 4'd1, 1'b0, 1'b1, 18'h00020);
    issue(0, 1'b1, 1'b1, 2'd0, 1'b0, 16'h0020, 16'h5A5A, 16'h0, 16'h0, 4'd1);
    pin(0, 2, 1, 16'h5A5A, 4'd7, 1'b1, 1'b1, 18'h00020);
    issue(0, 1'b1, 1'b0, 2'd1, 1'b1, 16'h0020, 16'h0000, 16'h0, 16'h0, 4'd7);

    // Abort a store in the middle of its strobe
    en[1] = 1'b1; op[1] = 1'b1; dop[1] = 2'd0; rop[1] = 1'b0;
    alu[1] = 16'h0040; wd[1] = 16'h1111; wba[1] = 4'd0;
    for (int n = 0; n < 20 && we_n[1] !== 1'b0; n++) begin
      @(posedge clk); #1;
    end
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 en[1] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    pin(1, 0, 0, 16'h0000, 4'd4, 1'b1, 1'b0, 18'h0);
    issue(1, 1'b0, 1'b0, 2'd1, 1'b1, 16'h0040, 16'h0, 16'h0, 16'h0, 4'd4);

    for (int k = 0; k < 200; k++) begin
      issue($urandom_range(0, 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 16'($urandom),
            16'($urandom), 16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
